cordic_iter_gen: RTL and testbench

- Parametrised, iterative CORDIC engine; successor to the fixed 16-bit rotation-only cordic unit.
- Supports two modes:
  - rotation: angle in, cos/sin out, over the full ±pi range.
  - vectoring: (x, y) in, magnitude and atan2 out.
- Uses a start/busy/done handshake. Serves the trig/polar-conversion datapath as a drop-in for the older unit.

---
 rtl/cordic_pkg.sv | 36 +++
 rtl/cordic_atan_rom.sv | 26 ++
 rtl/cordic_iter_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_cordic_iter_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, encodings and constant-table generators for the iterative CORDIC engine.
package cordic_pkg;

    localparam real PiR = 3.14159265358979323846;
    localparam real KR  = 0.6072529;

    typedef enum logic {
        ModeRot = 1'b0,
        ModeVec = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StIter,
        StPost
    } state_e;

    // pi, pi/2 and the CORDIC gain, rounded to nearest with `frac` fractional bits
    function automatic int pi_q(input int frac);
        return $rtoi(PiR * (2.0 ** frac) + 0.5);
    endfunction

    function automatic int pi2_q(input int frac);
        return $rtoi(PiR * 0.5 * (2.0 ** frac) + 0.5);
    endfunction

    function automatic int k_q(input int frac);
        return $rtoi(KR * (2.0 ** frac) + 0.5);
    endfunction

    function automatic int atan_q(input int i, input int frac);
        return $rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** frac) + 0.5);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational table of atan(2^-i) micro-rotation angles, built at elaboration time.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int unsigned ITER = 14,
    parameter int unsigned IW   = 20,
    parameter int unsigned FRAC = 15
) (
    input  logic [$clog2(ITER)-1:0] idx_i,
    output logic signed [IW-1:0]    atan_o
);

    logic signed [IW-1:0] table_w [ITER];

    for (genvar k = 0; k < ITER; k++) begin : g_atan
        assign table_w[k] = IW'(atan_q(k, FRAC));
    end

    always_comb begin
        atan_o = '0;
        for (int k = 0; k < ITER; k++) begin
            if (int'(idx_i) == k) atan_o = table_w[k];
        end
    end

endmodule

// File: rtl/cordic_iter_gen.sv
// Iterative CORDIC: rotation (angle -> cos/sin) and vectoring ((x,y) -> magnitude/atan2),
// one micro-rotation per cycle behind a start/busy/done handshake.
module cordic_iter_gen
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITER  = 14,
    parameter int unsigned GUARD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] angle,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic             range_err,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_b
);

    localparam int unsigned IW    = WIDTH + GUARD + 2;
    localparam int unsigned PW    = IW + WIDTH;
    localparam int unsigned IdxW  = $clog2(ITER);
    localparam int          ZFrac = WIDTH - 3 + GUARD;
    localparam int          PiW   = pi_q(WIDTH - 3);
    localparam int          Pi2W  = pi2_q(WIDTH - 3);
    localparam logic signed [IW-1:0] PiI = IW'(pi_q(ZFrac));
    localparam logic signed [IW-1:0] KI  = IW'(k_q(WIDTH - 2 + GUARD));
    localparam logic signed [PW-1:0] KW  = PW'(k_q(WIDTH - 2));
    localparam longint RndGL = (GUARD == 0) ? 0 : (longint'(1) << (GUARD - 1));
    localparam logic signed [PW-1:0] RndG   = PW'(RndGL);
    localparam logic signed [PW-1:0] RndK   = PW'(longint'(1) << (WIDTH - 3));
    localparam logic signed [PW-1:0] SatMax = PW'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SatMin = PW'(-(longint'(1) << (WIDTH - 1)));

    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic [IdxW-1:0]          iter_q, iter_d;
    logic                     neg_q, neg_d, err_q, err_d, zero_q, zero_d;
    logic signed [WIDTH-1:0]  ang_q, ang_d, xin_q, xin_d, yin_q, yin_d;
    logic signed [IW-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic                     done_q, done_d, range_err_q, range_err_d;
    logic [WIDTH-1:0]         res_a_q, res_a_d, res_b_q, res_b_d;

    logic signed [IW-1:0]     atan_w, ang_ext, xin_ext, yin_ext, xs, ys;
    logic signed [PW-1:0]     prod_w, post_a, post_b;
    logic                     d_pos;

    cordic_atan_rom #(
        .ITER (ITER),
        .IW   (IW),
        .FRAC (ZFrac)
    ) u_atan_rom (
        .idx_i  (iter_q),
        .atan_o (atan_w)
    );

    assign ang_ext = IW'(ang_q) <<< GUARD;
    assign xin_ext = IW'(xin_q) <<< GUARD;
    assign yin_ext = IW'(yin_q) <<< GUARD;
    assign xs      = x_q >>> iter_q;
    assign ys      = y_q >>> iter_q;
    assign prod_w  = PW'(x_q) * KW;
    // Rotation drives z toward 0 (d = sign z); vectoring drives y toward 0 (d = -sign y).
    assign d_pos   = (mode_q == ModeRot) ? ~z_q[IW-1] : y_q[IW-1];

    function automatic logic [WIDTH-1:0] rnd_sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] t;
        t = (v + RndG) >>> GUARD;
        if (t > SatMax) return SatMax[WIDTH-1:0];
        if (t < SatMin) return SatMin[WIDTH-1:0];
        return t[WIDTH-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        iter_d      = iter_q;
        neg_d       = neg_q;
        err_d       = err_q;
        zero_d      = zero_q;
        ang_d       = ang_q;
        xin_d       = xin_q;
        yin_d       = yin_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        done_d      = 1'b0;
        range_err_d = range_err_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        post_a      = '0;
        post_b      = '0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode_e'(mode);
                    ang_d   = angle;
                    xin_d   = x_in;
                    yin_d   = y_in;
                    state_d = StPre;
                end
            end
            StPre: begin
                iter_d  = '0;
                neg_d   = 1'b0;
                err_d   = 1'b0;
                zero_d  = 1'b0;
                state_d = StIter;
                if (mode_q == ModeRot) begin
                    x_d   = KI;
                    y_d   = '0;
                    err_d = (int'(ang_q) > PiW) || (int'(ang_q) < -PiW);
                    if (int'(ang_q) > Pi2W) begin
                        z_d   = ang_ext - PiI;
                        neg_d = 1'b1;
                    end else if (int'(ang_q) < -Pi2W) begin
                        z_d   = ang_ext + PiI;
                        neg_d = 1'b1;
                    end else begin
                        z_d = ang_ext;
                    end
                end else begin
                    // atan2 of the zero vector is undefined; force a clean zero result
                    zero_d = (xin_q == '0) && (yin_q == '0);
                    if (xin_q[WIDTH-1]) begin
                        x_d = -xin_ext;
                        y_d = -yin_ext;
                        z_d = yin_q[WIDTH-1] ? -PiI : PiI;
                    end else begin
                        x_d = xin_ext;
                        y_d = yin_ext;
                        z_d = '0;
                    end
                end
            end
            StIter: begin
                if (d_pos) begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_w;
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_w;
                end
                iter_d = iter_q + 1'b1;
                if (iter_q == IdxW'(ITER - 1)) state_d = StPost;
            end
            StPost: begin
                done_d      = 1'b1;
                range_err_d = err_q;
                state_d     = StIdle;
                if (mode_q == ModeRot) begin
                    post_a = neg_q ? -PW'(x_q) : PW'(x_q);
                    post_b = neg_q ? -PW'(y_q) : PW'(y_q);
                end else begin
                    post_a = (prod_w + RndK) >>> (WIDTH - 2);
                    post_b = PW'(z_q);
                end
                if (err_q || zero_q) begin
                    res_a_d = '0;
                    res_b_d = '0;
                end else begin
                    res_a_d = rnd_sat(post_a);
                    res_b_d = rnd_sat(post_b);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= ModeRot;
            iter_q      <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            zero_q      <= 1'b0;
            ang_q       <= '0;
            xin_q       <= '0;
            yin_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            res_a_q     <= '0;
            res_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            iter_q      <= iter_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            zero_q      <= zero_d;
            ang_q       <= ang_d;
            xin_q       <= xin_d;
            yin_q       <= yin_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign range_err = range_err_q;
    assign res_a     = res_a_q;
    assign res_b     = res_b_q;

endmodule

// File: tb/tb_cordic_iter_gen.sv
// Directed bench for cordic_iter_gen at WIDTH=16, ITER=14, GUARD=2 with hand-computed results.
module tb_cordic_iter_gen;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] angle = '0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic         busy, done, range_err;
    logic [W-1:0] res_a, res_b;

    int n_cmp = 0;
    int n_err = 0;
    int lat, bcnt, nd;

    cordic_iter_gen #(
        .WIDTH (16),
        .ITER  (14),
        .GUARD (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .angle     (angle),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .res_a     (res_a),
        .res_b     (res_b)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int act, input int exp);
        n_cmp++;
        assert ((act - exp) <= 3 && (exp - act) <= 3) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d +/-3", tag, act, exp);
        end
    endtask

    // Called at a negedge; the following posedge samples start.
    task automatic start_op(input logic m, input int a, input int x, input int y);
        mode  = m;
        angle = W'(a);
        x_in  = W'(x);
        y_in  = W'(y);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke, output int latency, output int busy_cycles);
        latency     = -1;
        busy_cycles = busy ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                latency = c;
                break;
            end
            if (busy) busy_cycles++;
            if (poke && (c == 3 || c == 7)) begin
                start = 1'b1;
                angle = W'(9000);
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    function automatic int sv(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_rerr", int'(range_err), 0);
        chk_eq("rst_res_a", sv(res_a), 0);
        chk_eq("rst_res_b", sv(res_b), 0);
        rst = 1'b0;
        @(negedge clk);

        // pi/6
        start_op(1'b0, 4289, 0, 0);
        wait_done(1'b0, lat, bcnt);
        chk_eq("pi6_latency", lat, 16);
        chk_eq("pi6_busy_cycles", bcnt, 16);
        chk_near("pi6_cos", sv(res_a), 14189);
        chk_near("pi6_sin", sv(res_b), 8192);
        chk_eq("pi6_rerr", int'(range_err), 0);

        // pi/4 started in the done cycle
        start_op(1'b0, 6434, 0, 0);
        chk_eq("b2b_accept_busy", int'(busy), 1);
        chk_near("b2b_hold_res_a", sv(res_a), 14189);
        wait_done(1'b0, lat, bcnt);
        chk_eq("pi4_latency", lat, 16);
        chk_near("pi4_cos", sv(res_a), 11585);
        chk_near("pi4_sin", sv(res_b), 11585);

        // -2.5 rad, third-quadrant fold
        start_op(1'b0, -20480, 0, 0);
        wait_done(1'b0, lat, bcnt);
        chk_near("m25_cos", sv(res_a), -13126);
        chk_near("m25_sin", sv(res_b), -9806);
        chk_eq("m25_rerr", int'(range_err), 0);

        // out of range
        start_op(1'b0, 26000, 0, 0);
        wait_done(1'b0, lat, bcnt);
        chk_eq("oor_rerr", int'(range_err), 1);
        chk_eq("oor_res_a", sv(res_a), 0);
        chk_eq("oor_res_b", sv(res_b), 0);

        // vectoring (-0.5, 0.5)
        start_op(1'b1, 0, -8192, 8192);
        wait_done(1'b0, lat, bcnt);
        chk_eq("vec_latency", lat, 16);
        chk_near("vec_mag", sv(res_a), 11585);
        chk_near("vec_atan2", sv(res_b), 19302);
        chk_eq("vec_rerr", int'(range_err), 0);

        // zero vector
        start_op(1'b1, 0, 0, 0);
        wait_done(1'b0, lat, bcnt);
        chk_eq("zero_mag", sv(res_a), 0);
        chk_eq("zero_atan2", sv(res_b), 0);

        // angle 0 with ignored start pulses at cycles 3 and 7
        start_op(1'b0, 0, 0, 0);
        wait_done(1'b1, lat, bcnt);
        chk_eq("poke_latency", lat, 16);
        chk_eq("poke_busy_cycles", bcnt, 16);
        chk_near("poke_cos", sv(res_a), 16384);
        chk_near("poke_sin", sv(res_b), 0);
        count_done(20, nd);
        chk_eq("poke_extra_done", nd, 0);

        // reset mid-iteration
        start_op(1'b0, 6434, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("abort_busy", int'(busy), 0);
        chk_eq("abort_done", int'(done), 0);
        chk_eq("abort_res_a", sv(res_a), 0);
        chk_eq("abort_res_b", sv(res_b), 0);
        count_done(30, nd);
        chk_eq("abort_no_done", nd, 0);

        // fresh op after abort
        start_op(1'b1, 0, -8192, 8192);
        wait_done(1'b0, lat, bcnt);
        chk_eq("fresh_latency", lat, 16);
        chk_near("fresh_mag", sv(res_a), 11585);
        chk_near("fresh_atan2", sv(res_b), 19302);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
